// File: rtl/itch_add_order_parser_if.sv
// =============================================================================
// Module   : itch_add_order_parser_if
// Brief    : Word-stream input and decoded-order output bundle for the parser.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface itch_add_order_parser_if #(
  parameter int REG_WIDTH = 32
);
  logic [REG_WIDTH-1:0] i_word;
  logic                 i_word_valid;
  logic                 i_word_first;
  logic                 o_word_ready;
  logic                 o_valid;
  logic                 i_ready;
  logic [15:0]          o_locate_code;
  logic [15:0]          o_tracking_number;
  logic [47:0]          o_timestamp;
  logic [63:0]          o_order_id;
  logic                 o_trade_type;
  logic [31:0]          o_quantity;
  logic [1:0]           o_stock_symbol;
  logic [31:0]          o_price;
  logic                 o_error;

  modport master (
    output i_word, i_word_valid, i_word_first, i_ready,
    input  o_word_ready, o_valid, o_locate_code, o_tracking_number, o_timestamp,
           o_order_id, o_trade_type, o_quantity, o_stock_symbol, o_price, o_error
  );

  modport slave (
    input  i_word, i_word_valid, i_word_first, i_ready,
    output o_word_ready, o_valid, o_locate_code, o_tracking_number, o_timestamp,
           o_order_id, o_trade_type, o_quantity, o_stock_symbol, o_price, o_error
  );
endinterface

`default_nettype wire

// File: rtl/itch_add_order_parser.sv
// =============================================================================
// Module   : itch_add_order_parser
// Brief    : Decodes 9-word ITCH Add Order messages into order-book fields.
//            Optional macro ITCH_TYPE_FILTER_EN drops non-'A' messages at word 0.
// Revision : 1.0
// =============================================================================
`default_nettype none

module itch_add_order_parser #(
  parameter int REG_WIDTH = 32,
  parameter int MSG_WORDS = 9
) (
  input  wire                      i_clk,
  input  wire                      i_reset,
  itch_add_order_parser_if.slave   bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_HOLD    = 2'd2;
  localparam logic [1:0] c_DROP    = 2'd3;
  localparam logic [3:0] c_LAST    = 4'(MSG_WORDS - 1);
  localparam logic [7:0] c_TYPE_ADD = 8'h41;

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic [REG_WIDTH-1:0] r_words [0:MSG_WORDS-2];
  logic                 r_valid;
  logic                 r_error;
  logic [15:0]          r_locate;
  logic [15:0]          r_tracking;
  logic [47:0]          r_timestamp;
  logic [63:0]          r_order_id;
  logic                 r_side;
  logic [31:0]          r_quantity;
  logic [1:0]           r_symbol;
  logic [31:0]          r_price;

  logic                 w_accept;
  logic [63:0]          w_stock;
  logic                 w_sym_known;
  logic [1:0]           w_sym;
  logic [1:0]           w_start_state;
  logic                 w_start_err;
  logic                 w_unused;

  assign w_accept = bus.i_word_valid && bus.o_word_ready;

  // Symbol bytes reordered so the first stream character is the MSB, matching string literals
  assign w_stock = {r_words[6][7:0], r_words[6][15:8], r_words[6][23:16], r_words[6][31:24],
                    r_words[7][7:0], r_words[7][15:8], r_words[7][23:16], r_words[7][31:24]};

  always_comb begin
    w_sym_known = 1'b1;
    w_sym       = 2'd0;
    case (w_stock)
      "AAPL    ": w_sym = 2'd0;
      "AMZN    ": w_sym = 2'd1;
      "GOOGL   ": w_sym = 2'd2;
      "MSFT    ": w_sym = 2'd3;
      default:    w_sym_known = 1'b0;
    endcase
  end

`ifdef ITCH_TYPE_FILTER_EN
  assign w_start_err   = (bus.i_word[7:0] != c_TYPE_ADD);
  assign w_start_state = w_start_err ? c_DROP : c_COLLECT;
`else
  assign w_start_err   = 1'b0;
  assign w_start_state = c_COLLECT;
`endif

  assign w_unused = ^{r_words[4][31:25]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= c_IDLE;
      r_cnt       <= 4'd0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_locate    <= '0;
      r_tracking  <= '0;
      r_timestamp <= '0;
      r_order_id  <= '0;
      r_side      <= 1'b0;
      r_quantity  <= '0;
      r_symbol    <= '0;
      r_price     <= '0;
      for (int i = 0; i < MSG_WORDS - 1; i++) r_words[i] <= '0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept && bus.i_word_first) begin
            r_words[0] <= bus.i_word;
            r_cnt      <= 4'd1;
            r_state    <= w_start_state;
            r_error    <= w_start_err;
          end
        end
        c_COLLECT: begin
          if (w_accept) begin
            if (bus.i_word_first) begin
              r_words[0] <= bus.i_word;
              r_cnt      <= 4'd1;
              r_state    <= w_start_state;
              r_error    <= 1'b1;
            end else if (r_cnt == c_LAST) begin
              r_cnt <= 4'd0;
              // Price is taken straight from the final word; it is never stored
              if ((r_words[0][7:0] == c_TYPE_ADD) && w_sym_known) begin
                r_locate    <= r_words[0][23:8];
                r_tracking  <= {r_words[1][7:0], r_words[0][31:24]};
                r_timestamp <= {r_words[2][23:0], r_words[1][31:8]};
                r_order_id  <= {r_words[4][23:0], r_words[3], r_words[2][31:24]};
                r_side      <= r_words[4][24];
                r_quantity  <= r_words[5];
                r_symbol    <= w_sym;
                r_price     <= bus.i_word;
                r_valid     <= 1'b1;
                r_state     <= c_HOLD;
              end else begin
                r_error <= 1'b1;
                r_state <= c_IDLE;
              end
            end else begin
              r_words[r_cnt[2:0]] <= bus.i_word;
              r_cnt               <= r_cnt + 4'd1;
            end
          end
        end
        c_HOLD: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: begin
          if (w_accept) begin
            if (bus.i_word_first) begin
              r_words[0] <= bus.i_word;
              r_cnt      <= 4'd1;
              r_state    <= w_start_state;
              r_error    <= w_start_err;
            end else if (r_cnt == c_LAST) begin
              r_cnt   <= 4'd0;
              r_state <= c_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_word_ready      = !i_reset && (r_state != c_HOLD);
  assign bus.o_valid           = r_valid;
  assign bus.o_error           = r_error;
  assign bus.o_locate_code     = r_locate;
  assign bus.o_tracking_number = r_tracking;
  assign bus.o_timestamp       = r_timestamp;
  assign bus.o_order_id        = r_order_id;
  assign bus.o_trade_type      = r_side;
  assign bus.o_quantity        = r_quantity;
  assign bus.o_stock_symbol    = r_symbol;
  assign bus.o_price           = r_price;

endmodule

`default_nettype wire

// File: tb/tb_itch_add_order_parser.sv
// =============================================================================
// Module   : tb_itch_add_order_parser
// Brief    : Directed-vector scoreboard bench for itch_add_order_parser.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_itch_add_order_parser;

  typedef struct {
    bit          is_err;
    logic [15:0] locate;
    logic [15:0] tracking;
    logic [47:0] ts;
    logic [63:0] oid;
    logic        side;
    logic [31:0] qty;
    logic [1:0]  sym;
    logic [31:0] price;
  } exp_t;

  logic i_clk;
  logic i_reset;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] msg [9];

  itch_add_order_parser_if #(.REG_WIDTH(32)) bus ();

  itch_add_order_parser #(.REG_WIDTH(32), .MSG_WORDS(9)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte-level model: byte k lands in word k/4 at bits [8*(k%4)+7 -: 8]
  task automatic make(input logic [7:0] typ, input logic [15:0] locate, input logic [15:0] tracking,
                      input logic [47:0] ts, input logic [63:0] oid, input logic side,
                      input logic [31:0] qty, input logic [63:0] stock, input logic [31:0] price,
                      input logic [1:0] sym);
    logic [7:0] b [36];
    b[0] = typ;
    for (int i = 0; i < 2; i++) b[1 + i]  = locate[8*i +: 8];
    for (int i = 0; i < 2; i++) b[3 + i]  = tracking[8*i +: 8];
    for (int i = 0; i < 6; i++) b[5 + i]  = ts[8*i +: 8];
    for (int i = 0; i < 8; i++) b[11 + i] = oid[8*i +: 8];
    b[19] = {7'd0, side};
    for (int i = 0; i < 4; i++) b[20 + i] = qty[8*i +: 8];
    for (int i = 0; i < 8; i++) b[24 + i] = stock[63 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[32 + i] = price[8*i +: 8];
    for (int w = 0; w < 9; w++) msg[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
    cur.is_err = 1'b0; cur.locate = locate; cur.tracking = tracking; cur.ts = ts;
    cur.oid = oid; cur.side = side; cur.qty = qty; cur.sym = sym; cur.price = price;
  endtask

  task automatic push_err();
    exp_t e;
    e = cur;
    e.is_err = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input bit first);
    int t = 0;
    bus.i_word = w; bus.i_word_first = first; bus.i_word_valid = 1'b1;
    while (!bus.o_word_ready && t < 50) begin @(posedge i_clk); #1; t++; end
    if (!bus.o_word_ready) begin
      n_vec++; n_err++;
      $display("FAIL word_ready_timeout: got 0, expected 1");
    end
    @(posedge i_clk); #1;
    bus.i_word_valid = 1'b0; bus.i_word_first = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_word(msg[i], i == 0);
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_locate"},   bus.o_locate_code,     cur.locate);
    chk({tag, "_tracking"}, bus.o_tracking_number, cur.tracking);
    chk({tag, "_ts"},       bus.o_timestamp,       cur.ts);
    chk({tag, "_oid"},      bus.o_order_id,        cur.oid);
    chk({tag, "_side"},     bus.o_trade_type,      cur.side);
    chk({tag, "_qty"},      bus.o_quantity,        cur.qty);
    chk({tag, "_sym"},      bus.o_stock_symbol,    cur.sym);
    chk({tag, "_price"},    bus.o_price,           cur.price);
  endtask

  // Monitor: every o_error pulse and every output handshake pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (bus.o_error === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL unexpected_error: got error pulse, expected nothing");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err) begin
            n_err++; $display("FAIL event_kind: got error pulse, expected order");
          end
        end
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL unexpected_order: got order, expected nothing");
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind",     {63'd0, e.is_err},     64'd0);
          chk("mon_locate",   bus.o_locate_code,     e.locate);
          chk("mon_tracking", bus.o_tracking_number, e.tracking);
          chk("mon_ts",       bus.o_timestamp,       e.ts);
          chk("mon_oid",      bus.o_order_id,        e.oid);
          chk("mon_side",     bus.o_trade_type,      e.side);
          chk("mon_qty",      bus.o_quantity,        e.qty);
          chk("mon_sym",      bus.o_stock_symbol,    e.sym);
          chk("mon_price",    bus.o_price,           e.price);
        end
      end
    end
  end

  initial begin
    bus.i_word = '0; bus.i_word_valid = 1'b0; bus.i_word_first = 1'b0; bus.i_ready = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_error", bus.o_error, 0);
    chk("rst_ready", bus.o_word_ready, 0);
    chk("rst_price", bus.o_price, 0);
    chk("rst_oid",   bus.o_order_id, 0);
    i_reset = 1'b0;
    #1;
    chk("rst_release_ready", bus.o_word_ready, 1);

    // Non-first word in IDLE is discarded without error
    send_word(32'hDEADBEEF, 1'b0);
    chk("idle_junk_error", bus.o_error, 0);

    // Legal AAPL BUY, downstream always ready
    make(8'h41, 16'h0102, 16'h0304, 48'h0000_1122_3344, 64'd7, 1'b0, 32'd100, "AAPL    ", 32'h0001_86A0, 2'd0);
    exp_q.push_back(cur);
    send_range(0, 8);
    chk("t1_valid_rise", bus.o_valid, 1);
    chk_fields("t1");
    @(posedge i_clk); #1;
    chk("t1_valid_fall", bus.o_valid, 0);

    // Same message with downstream stalled for 5 cycles
    bus.i_ready = 1'b0;
    exp_q.push_back(cur);
    send_range(0, 8);
    chk("t2_valid_c1", bus.o_valid, 1);
    chk("t2_wready_c1", bus.o_word_ready, 0);
    for (int c = 2; c <= 5; c++) begin
      @(posedge i_clk); #1;
      chk("t2_valid_hold", bus.o_valid, 1);
      chk("t2_wready_hold", bus.o_word_ready, 0);
      chk_fields("t2_hold");
    end
    @(posedge i_clk); #1;
    bus.i_ready = 1'b1;
    chk("t2_valid_c6", bus.o_valid, 1);
    chk_fields("t2_c6");
    @(posedge i_clk); #1;
    chk("t2_valid_fall", bus.o_valid, 0);
    chk("t2_wready_back", bus.o_word_ready, 1);

    // Next message after the stall: AMZN SELL
    make(8'h41, 16'hBEEF, 16'h0042, 48'hFEDC_BA98_7654, 64'h0123_4567_89AB_CDEF, 1'b1, 32'hDEAD_0001, "AMZN    ", 32'h8000_0001, 2'd1);
    exp_q.push_back(cur);
    send_range(0, 8);
    chk("t2b_valid", bus.o_valid, 1);
    chk_fields("t2b");
    @(posedge i_clk); #1;

    // Unknown symbol
    make(8'h41, 16'h0001, 16'h0002, 48'd3, 64'd4, 1'b0, 32'd5, "XYZ     ", 32'd6, 2'd0);
    push_err();
    send_range(0, 8);
    chk("t3_error", bus.o_error, 1);
    chk("t3_valid", bus.o_valid, 0);
    @(posedge i_clk); #1;
    chk("t3_error_pulse", bus.o_error, 0);

    // Abort at word 4 by a new first word, then a complete MSFT message
    make(8'h41, 16'h1111, 16'h2222, 48'd3, 64'd4, 1'b0, 32'd5, "AAPL    ", 32'd6, 2'd0);
    send_range(0, 3);
    make(8'h41, 16'h0A0B, 16'h0C0D, 48'h0102_0304_0506, 64'h1122_3344_5566_7788, 1'b1, 32'd250, "MSFT    ", 32'h0000_2710, 2'd3);
    push_err();
    exp_q.push_back(cur);
    send_word(msg[0], 1'b1);
    chk("t4_abort_error", bus.o_error, 1);
    send_range(1, 8);
    chk("t4_valid", bus.o_valid, 1);
    chk("t4_sym", bus.o_stock_symbol, 3);
    @(posedge i_clk); #1;

    // Reset in the middle of a message
    send_range(0, 4);
    i_reset = 1'b1;
    #1;
    chk("t5_rst_valid", bus.o_valid, 0);
    chk("t5_rst_ready", bus.o_word_ready, 0);
    chk("t5_rst_price", bus.o_price, 0);
    chk("t5_rst_sym",   bus.o_stock_symbol, 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    chk("t5_release_ready", bus.o_word_ready, 1);
    make(8'h41, 16'h7777, 16'h8888, 48'h0000_0000_0099, 64'd12345, 1'b0, 32'd1, "GOOGL   ", 32'd42, 2'd2);
    exp_q.push_back(cur);
    send_range(0, 8);
    chk("t5_valid", bus.o_valid, 1);
    chk_fields("t5");
    @(posedge i_clk); #1;

    // Wrong message type 0x44
    make(8'h44, 16'h0102, 16'h0304, 48'h0000_1122_3344, 64'd7, 1'b0, 32'd100, "AAPL    ", 32'h0001_86A0, 2'd0);
    push_err();
    send_range(0, 0);
`ifdef ITCH_TYPE_FILTER_EN
    chk("t6_early_error", bus.o_error, 1);
`else
    chk("t6_no_early_error", bus.o_error, 0);
`endif
    send_range(1, 8);
`ifdef ITCH_TYPE_FILTER_EN
    chk("t6_late_error", bus.o_error, 0);
`else
    chk("t6_late_error", bus.o_error, 1);
`endif
    chk("t6_valid", bus.o_valid, 0);
    @(posedge i_clk); #1;
    chk("t6_valid_after", bus.o_valid, 0);

    repeat (5) @(posedge i_clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
